note_lane_array: RTL and testbench

Parametrised multi-lane falling-note engine for the game playfield. It generalises the single-lane fixed-colour sprite to NUM_LANES lanes, each holding up to SLOTS notes in flight. On each frame it spawns, scrolls and retires notes, and it resolves player strum strobes against a hit window. It sits between the note-chart/RNG source and the colour mapper, which consumes the per-lane draw flags.

---
 rtl/note_lane_array.sv | 142 ++++++++++++++
 tb/tb_note_lane_array.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/note_lane_array.sv
// note_lane_array: multi-lane falling-note engine; spawns, scrolls, retires and hit-resolves
// notes once per frame tick and flags pixels covered by active notes.
module note_lane_array #(
    parameter int NUM_LANES  = 5,
    parameter int SLOTS      = 4,
    parameter int NOTE_SIZE  = 40,
    parameter int Y_STEP     = 3,
    parameter int Y_MAX      = 479,
    parameter int LANE_X0    = 100,
    parameter int LANE_PITCH = 100,
    parameter int HIT_Y_LO   = 400,
    parameter int HIT_Y_HI   = 460
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [NUM_LANES-1:0] spawn,
    input  logic [NUM_LANES-1:0] hit,
    output logic [NUM_LANES-1:0] is_note,
    output logic [NUM_LANES-1:0] hit_ok,
    output logic [NUM_LANES-1:0] hit_bad,
    output logic [NUM_LANES-1:0] miss,
    output logic [NUM_LANES-1:0] spawn_drop
);
    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam logic [9:0]  HLO   = 10'(HIT_Y_LO);
    localparam logic [9:0]  HHI   = 10'(HIT_Y_HI);
    localparam logic [9:0]  NSZ10 = 10'(NOTE_SIZE);
    localparam logic [10:0] NSZ11 = 11'(NOTE_SIZE);
    localparam logic [10:0] STEP  = 11'(Y_STEP);
    localparam logic [10:0] YMAX  = 11'(Y_MAX);

    logic [SLOTS-1:0]     act   [NUM_LANES];
    logic [SLOTS-1:0]     act_n [NUM_LANES];
    logic [9:0]           y     [NUM_LANES][SLOTS];
    logic [9:0]           y_n   [NUM_LANES][SLOTS];
    logic                 frame_clk_s, frame_clk_d, tick;
    logic [NUM_LANES-1:0] ok_n, bad_n, miss_n, drop_n;
    logic                 found, free_found, close;
    logic [SW-1:0]        sel, fsel;
    logic [9:0]           sel_y;
    logic [10:0]          nxt, xl;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_s <= 1'b1;
            frame_clk_d <= 1'b1;
            tick        <= 1'b0;
            act         <= '{default: '0};
            y           <= '{default: '0};
            hit_ok      <= '0;
            hit_bad     <= '0;
            miss        <= '0;
            spawn_drop  <= '0;
        end else begin
            frame_clk_s <= frame_clk;
            frame_clk_d <= frame_clk_s;
            tick        <= frame_clk_s & ~frame_clk_d;
            act         <= act_n;
            y           <= y_n;
            hit_ok      <= ok_n;
            hit_bad     <= bad_n;
            miss        <= miss_n;
            spawn_drop  <= drop_n;
        end
    end

    // Hit removal happens first so the removed slot neither advances nor retires, and is free to spawn into.
    always_comb begin
        act_n      = act;
        y_n        = y;
        ok_n       = '0;
        bad_n      = '0;
        miss_n     = '0;
        drop_n     = '0;
        found      = 1'b0;
        free_found = 1'b0;
        close      = 1'b0;
        sel        = '0;
        fsel       = '0;
        sel_y      = '0;
        nxt        = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            found = 1'b0;
            sel   = '0;
            sel_y = '0;
            for (int s = 0; s < SLOTS; s++)
                if (hit[l] && act[l][s] && y[l][s] >= HLO && y[l][s] <= HHI && (!found || y[l][s] > sel_y)) begin
                    found = 1'b1;
                    sel   = SW'(s);
                    sel_y = y[l][s];
                end
            ok_n[l]  = found;
            bad_n[l] = hit[l] & ~found;
            if (found)
                act_n[l][sel] = 1'b0;
            if (tick) begin
                close = 1'b0;
                for (int s = 0; s < SLOTS; s++)
                    if (act_n[l][s]) begin
                        close = close | (y[l][s] < NSZ10);
                        nxt   = {1'b0, y[l][s]} + STEP;
                        if (nxt > YMAX) begin
                            act_n[l][s] = 1'b0;
                            miss_n[l]   = 1'b1;
                        end else
                            y_n[l][s] = nxt[9:0];
                    end
                free_found = 1'b0;
                fsel       = '0;
                for (int s = 0; s < SLOTS; s++)
                    if (!act_n[l][s] && !free_found) begin
                        free_found = 1'b1;
                        fsel       = SW'(s);
                    end
                if (spawn[l]) begin
                    if (!free_found || close)
                        drop_n[l] = 1'b1;
                    else begin
                        act_n[l][fsel] = 1'b1;
                        y_n[l][fsel]   = '0;
                    end
                end
            end
        end
    end

    // Bounds are 11 bits wide so a note near the bottom row cannot wrap back to the top.
    always_comb begin
        is_note = '0;
        xl      = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            xl = 11'(LANE_X0 + l * LANE_PITCH);
            for (int s = 0; s < SLOTS; s++)
                is_note[l] = is_note[l] | (act[l][s]
                    & ({1'b0, DrawX} >= xl) & ({1'b0, DrawX} < xl + NSZ11)
                    & ({1'b0, DrawY} >= {1'b0, y[l][s]}) & ({1'b0, DrawY} < {1'b0, y[l][s]} + NSZ11));
        end
    end
endmodule

// File: tb/tb_note_lane_array.sv
// tb_note_lane_array: directed checks of spawn, scroll, retire, hit window, draw and reset behaviour.
module tb_note_lane_array;
    logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [4:0] spawn = '0, hit = '0;
    logic [4:0] is_note, hit_ok, hit_bad, miss, spawn_drop;
    int errors = 0, checks = 0;
    int ok_c[5]   = '{default: 0};
    int bad_c[5]  = '{default: 0};
    int miss_c[5] = '{default: 0};
    int drop_c[5] = '{default: 0};

    note_lane_array dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .spawn(spawn), .hit(hit),
        .is_note(is_note), .hit_ok(hit_ok), .hit_bad(hit_bad),
        .miss(miss), .spawn_drop(spawn_drop)
    );

    always #5 Clk = ~Clk;

    // Pulse widths are checked as cycle counts sampled on the falling edge.
    always @(negedge Clk)
        for (int l = 0; l < 5; l++) begin
            ok_c[l]   += int'(hit_ok[l]);
            bad_c[l]  += int'(hit_bad[l]);
            miss_c[l] += int'(miss[l]);
            drop_c[l] += int'(spawn_drop[l]);
        end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input int l, input int x, input int yy, input int exp);
        DrawX = 10'(x);
        DrawY = 10'(yy);
        #1;
        chk(tag, int'(is_note[l]), exp);
    endtask

    // One frame: the update edge is the third rising edge after frame_clk rises; h is driven onto that edge.
    task automatic tick(input logic [4:0] sp, input logic [4:0] h);
        frame_clk = 1'b1;
        spawn     = sp;
        repeat (2) @(negedge Clk);
        hit = h;
        @(negedge Clk);
        hit       = '0;
        spawn     = '0;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(5'b0, 5'b0);
    endtask

    task automatic strum(input logic [4:0] h);
        hit = h;
        @(negedge Clk);
        hit = '0;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_is_note", int'(is_note), 0);
        chk("rst_pulses", int'(hit_ok | hit_bad | miss | spawn_drop), 0);

        tick(5'b00001, 5'b0);
        pix("l0_spawn_y0", 0, 100, 0, 1);
        ticks(10);
        pix("l0_y30_in", 0, 100, 30, 1);
        pix("l0_x_edge", 0, 140, 30, 0);
        pix("l0_y_edge", 0, 100, 70, 0);
        pix("l0_corner", 0, 139, 69, 1);
        pix("l0_above", 0, 100, 29, 0);
        ticks(149);
        pix("l0_y477", 0, 100, 477, 1);
        chk("l0_no_miss_yet", miss_c[0], 0);
        tick(5'b0, 5'b0);
        chk("l0_miss_once", miss_c[0], 1);
        pix("l0_retired", 0, 100, 477, 0);
        tick(5'b0, 5'b0);
        chk("l0_miss_stays", miss_c[0], 1);

        tick(5'b00100, 5'b0);
        tick(5'b00100, 5'b0);
        chk("l2_drop_close", drop_c[2], 1);
        ticks(12);
        tick(5'b00100, 5'b0);
        chk("l2_drop_y39", drop_c[2], 2);
        tick(5'b00100, 5'b0);
        chk("l2_accept_y42", drop_c[2], 2);
        pix("l2_new_y0", 2, 300, 0, 1);
        pix("l2_gap", 2, 300, 42, 0);
        pix("l2_old_y45", 2, 300, 45, 1);
        pix("l2_old_end", 2, 339, 84, 1);
        pix("l2_old_below", 2, 300, 85, 0);
        ticks(14);
        tick(5'b00100, 5'b0);
        chk("l2_slot2", drop_c[2], 2);
        ticks(14);
        tick(5'b00100, 5'b0);
        chk("l2_slot3", drop_c[2], 2);
        ticks(14);
        tick(5'b00100, 5'b0);
        chk("l2_full_drop", drop_c[2], 3);
        chk("l0_no_drop", drop_c[0], 0);

        tick(5'b01010, 5'b0);
        ticks(14);
        tick(5'b01000, 5'b0);
        ticks(118);
        strum(5'b00010);
        chk("l1_bad_y399", bad_c[1], 1);
        chk("l1_no_ok_y399", ok_c[1], 0);
        pix("l1_kept", 1, 200, 399, 1);
        tick(5'b0, 5'b0);
        strum(5'b00011);
        chk("l1_ok_y402", ok_c[1], 1);
        chk("l1_bad_stays", bad_c[1], 1);
        chk("l0_bad_empty", bad_c[0], 1);
        pix("l1_removed", 1, 200, 402, 0);
        ticks(16);
        pix("l3_y450", 3, 400, 450, 1);
        pix("l3_gap", 3, 400, 445, 0);
        pix("l3_y405", 3, 400, 405, 1);
        tick(5'b0, 5'b01000);
        chk("l3_ok", ok_c[3], 1);
        chk("l3_no_bad", bad_c[3], 0);
        chk("l3_no_miss", miss_c[3], 0);
        pix("l3_adv_408", 3, 400, 408, 1);
        pix("l3_adv_447", 3, 400, 447, 1);
        pix("l3_adv_448", 3, 400, 448, 0);
        pix("l3_old_gone", 3, 400, 470, 0);
        ticks(23);
        chk("l3_no_miss_477", miss_c[3], 0);
        tick(5'b0, 5'b0);
        chk("l3_miss", miss_c[3], 1);
        pix("l3_retired", 3, 400, 477, 0);
        chk("l1_no_miss", miss_c[1], 0);

        tick(5'b10000, 5'b0);
        pix("l4_spawn", 4, 500, 0, 1);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_reset_clear", int'(is_note), 0);
        frame_clk = 1'b1;
        spawn     = 5'b10000;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (6) @(negedge Clk);
        pix("no_tick_at_release", 4, 500, 0, 0);
        chk("reset_no_drop", drop_c[4], 0);
        chk("reset_no_miss", miss_c[3], 1);
        frame_clk = 1'b0;
        spawn     = '0;
        repeat (2) @(negedge Clk);
        tick(5'b10000, 5'b0);
        pix("tick_after_release", 4, 500, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
